// File: rtl/regfile_writeback_arbiter.sv
// Round-robin arbiter sharing the register file's single writeback port among
// PORTCOUNT return-path requesters, with one registered output stage.
module regfile_writeback_arbiter #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int PORTCOUNT       = 4,
  parameter int GRANTBITWIDTH   = 2,
  parameter int COUNTBITWIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 async_rst_n,
  input  logic                                 clk_en,
  input  logic [PORTCOUNT-1:0]                 Req_Valid,
  input  logic [PORTCOUNT*REGADDRBITWIDTH-1:0] Req_Address,
  input  logic [PORTCOUNT*DATABITWIDTH-1:0]    Req_Data,
  output logic [PORTCOUNT-1:0]                 Req_Ready,
  output logic                                 Mem_Write_En,
  output logic [REGADDRBITWIDTH-1:0]           Mem_Write_Address,
  output logic [DATABITWIDTH-1:0]              Mem_Write_Data,
  output logic [GRANTBITWIDTH-1:0]             Grant_Index,
  output logic                                 Busy,
  output logic [COUNTBITWIDTH-1:0]             Write_Count
);

  localparam logic [GRANTBITWIDTH:0]   PORTCOUNT_W = PORTCOUNT[GRANTBITWIDTH:0];
  localparam logic [GRANTBITWIDTH-1:0] LAST_INDEX  = GRANTBITWIDTH'(PORTCOUNT - 1);
  localparam logic [COUNTBITWIDTH-1:0] COUNT_MAX   = {COUNTBITWIDTH{1'b1}};

  logic [GRANTBITWIDTH-1:0]   rrPointer_r;
  logic                       memWriteEn_r;
  logic [REGADDRBITWIDTH-1:0] memWriteAddress_r;
  logic [DATABITWIDTH-1:0]    memWriteData_r;
  logic [GRANTBITWIDTH-1:0]   grantIndex_r;
  logic [COUNTBITWIDTH-1:0]   writeCount_r;

  logic                       grantFound_s;
  logic [GRANTBITWIDTH-1:0]   grantIdx_s;
  logic [GRANTBITWIDTH:0]     candSum_s;
  logic [GRANTBITWIDTH-1:0]   candIdx_s;
  logic [GRANTBITWIDTH-1:0]   nextPointer_s;
  logic [REGADDRBITWIDTH-1:0] selAddress_s;
  logic [DATABITWIDTH-1:0]    selData_s;
  logic                       transfer_s;
  logic                       selNonZero_s;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grantFound_s = 1'b0;
    grantIdx_s   = {GRANTBITWIDTH{1'b0}};
    candSum_s    = {(GRANTBITWIDTH+1){1'b0}};
    candIdx_s    = {GRANTBITWIDTH{1'b0}};
    for (int i = 0; i < PORTCOUNT; i++) begin
      candSum_s = {1'b0, rrPointer_r} + i[GRANTBITWIDTH:0];
      if (candSum_s >= PORTCOUNT_W) begin
        candSum_s = candSum_s - PORTCOUNT_W;
      end else begin
        candSum_s = candSum_s;
      end
      candIdx_s = candSum_s[GRANTBITWIDTH-1:0];
      if (!grantFound_s && Req_Valid[candIdx_s]) begin
        grantFound_s = 1'b1;
        grantIdx_s   = candIdx_s;
      end else begin
        grantFound_s = grantFound_s;
      end
    end
  end

  // One-hot ready plus the granted requester's address/data slices.
  always_comb begin
    Req_Ready    = {PORTCOUNT{1'b0}};
    selAddress_s = {REGADDRBITWIDTH{1'b0}};
    selData_s    = {DATABITWIDTH{1'b0}};
    for (int i = 0; i < PORTCOUNT; i++) begin
      if (grantIdx_s == i[GRANTBITWIDTH-1:0]) begin
        Req_Ready[i] = async_rst_n & clk_en & grantFound_s;
        selAddress_s = Req_Address[i*REGADDRBITWIDTH +: REGADDRBITWIDTH];
        selData_s    = Req_Data[i*DATABITWIDTH +: DATABITWIDTH];
      end else begin
        Req_Ready[i] = 1'b0;
      end
    end
  end

  // Pointer successor of the current grant, wrapping modulo PORTCOUNT.
  always_comb begin
    if (grantIdx_s == LAST_INDEX) begin
      nextPointer_s = {GRANTBITWIDTH{1'b0}};
    end else begin
      nextPointer_s = grantIdx_s + {{(GRANTBITWIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign transfer_s   = clk_en & grantFound_s;
  assign selNonZero_s = (selAddress_s != {REGADDRBITWIDTH{1'b0}});

  // Output stage, RR pointer and saturating write counter.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rrPointer_r       <= {GRANTBITWIDTH{1'b0}};
      memWriteEn_r      <= 1'b0;
      memWriteAddress_r <= {REGADDRBITWIDTH{1'b0}};
      memWriteData_r    <= {DATABITWIDTH{1'b0}};
      grantIndex_r      <= {GRANTBITWIDTH{1'b0}};
      writeCount_r      <= {COUNTBITWIDTH{1'b0}};
    end else if (transfer_s) begin
      rrPointer_r       <= nextPointer_s;
      memWriteAddress_r <= selAddress_s;
      memWriteData_r    <= selData_s;
      grantIndex_r      <= grantIdx_s;
      // Register 0 is hardwired: accepted but never written or counted.
      memWriteEn_r      <= selNonZero_s;
      if (selNonZero_s && (writeCount_r != COUNT_MAX)) begin
        writeCount_r <= writeCount_r + {{(COUNTBITWIDTH-1){1'b0}}, 1'b1};
      end else begin
        writeCount_r <= writeCount_r;
      end
    end else begin
      memWriteEn_r <= 1'b0;
    end
  end

  assign Mem_Write_En      = memWriteEn_r;
  assign Mem_Write_Address = memWriteAddress_r;
  assign Mem_Write_Data    = memWriteData_r;
  assign Grant_Index       = grantIndex_r;
  assign Write_Count       = writeCount_r;
  assign Busy              = (|Req_Valid) | memWriteEn_r;

endmodule
